// File: rtl/bus_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory bus seen by
// bus_arbiter. The arbiter uses the slave view; the core/memory side uses master.
interface bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    // fetch port
    logic                  ir_req_valid;
    logic                  ir_req_ready;
    logic [ADDR_WIDTH-1:0] ir_req_addr;
    logic                  ir_resp_valid;
    logic                  ir_resp_ready;
    logic [DATA_WIDTH-1:0] ir_resp_data;
    // load/store port
    logic                  dr_req_valid;
    logic                  dr_req_ready;
    logic [ADDR_WIDTH-1:0] dr_req_addr;
    logic                  dr_req_write;
    logic [DATA_WIDTH-1:0] dr_req_wdata;
    logic [STRB_WIDTH-1:0] dr_req_wstrb;
    logic                  dr_resp_valid;
    logic                  dr_resp_ready;
    logic [DATA_WIDTH-1:0] dr_resp_data;
    // memory bus
    logic                  m_req_valid;
    logic                  m_req_ready;
    logic [ADDR_WIDTH-1:0] m_req_addr;
    logic                  m_req_write;
    logic [DATA_WIDTH-1:0] m_req_wdata;
    logic [STRB_WIDTH-1:0] m_req_wstrb;
    logic                  m_resp_valid;
    logic                  m_resp_ready;
    logic [DATA_WIDTH-1:0] m_resp_data;

    modport slave (
        input  ir_req_valid, ir_req_addr, ir_resp_ready,
        output ir_req_ready, ir_resp_valid, ir_resp_data,
        input  dr_req_valid, dr_req_addr, dr_req_write, dr_req_wdata, dr_req_wstrb, dr_resp_ready,
        output dr_req_ready, dr_resp_valid, dr_resp_data,
        output m_req_valid, m_req_addr, m_req_write, m_req_wdata, m_req_wstrb, m_resp_ready,
        input  m_req_ready, m_resp_valid, m_resp_data
    );

    modport master (
        output ir_req_valid, ir_req_addr, ir_resp_ready,
        input  ir_req_ready, ir_resp_valid, ir_resp_data,
        output dr_req_valid, dr_req_addr, dr_req_write, dr_req_wdata, dr_req_wstrb, dr_resp_ready,
        input  dr_req_ready, dr_resp_valid, dr_resp_data,
        input  m_req_valid, m_req_addr, m_req_write, m_req_wdata, m_req_wstrb, m_resp_ready,
        output m_req_ready, m_resp_valid, m_resp_data
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and
// load/store. One transaction in flight: grant -> issue request -> route response.
module bus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic            clk,
    input  logic            rst,
    bus_arbiter_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] O_NONE = 2'd0;
    localparam logic [1:0] O_INST = 2'd1;
    localparam logic [1:0] O_DATA = 2'd2;

    localparam logic G_INST = 1'b0;
    localparam logic G_DATA = 1'b1;

    logic [1:0]            state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic                  last_q,  last_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;

    logic gnt_ir, gnt_dr;
    logic in_resp_ir, in_resp_dr;
    logic m_resp_rdy;

    // Grant only in IDLE; on a tie the port that did not win last time goes first.
    always_comb begin
        gnt_ir = (state_q == S_IDLE) && bus.ir_req_valid &&
                 (!bus.dr_req_valid || last_q == G_DATA);
        gnt_dr = (state_q == S_IDLE) && bus.dr_req_valid &&
                 (!bus.ir_req_valid || last_q == G_INST);
    end

    assign in_resp_ir = (state_q == S_RESP) && (owner_q == O_INST);
    assign in_resp_dr = (state_q == S_RESP) && (owner_q == O_DATA);
    assign m_resp_rdy = (in_resp_ir && bus.ir_resp_ready) || (in_resp_dr && bus.dr_resp_ready);

    assign bus.ir_req_ready  = gnt_ir;
    assign bus.dr_req_ready  = gnt_dr;
    assign bus.m_req_valid   = (state_q == S_REQ);
    assign bus.m_req_addr    = addr_q;
    assign bus.m_req_write   = write_q;
    assign bus.m_req_wdata   = wdata_q;
    assign bus.m_req_wstrb   = wstrb_q;
    assign bus.m_resp_ready  = m_resp_rdy;
    // response data is passed through only to the current owner, zero otherwise
    assign bus.ir_resp_valid = in_resp_ir && bus.m_resp_valid;
    assign bus.dr_resp_valid = in_resp_dr && bus.m_resp_valid;
    assign bus.ir_resp_data  = in_resp_ir ? bus.m_resp_data : '0;
    assign bus.dr_resp_data  = in_resp_dr ? bus.m_resp_data : '0;

    // Next state: capture the winner, hold the request until accepted, wait for the response.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_dr) begin
                    state_d = S_REQ;
                    owner_d = O_DATA;
                    last_d  = G_DATA;
                    addr_d  = bus.dr_req_addr;
                    write_d = bus.dr_req_write;
                    wdata_d = bus.dr_req_wdata;
                    wstrb_d = bus.dr_req_wstrb;
                end else if (gnt_ir) begin
                    state_d = S_REQ;
                    owner_d = O_INST;
                    last_d  = G_INST;
                    addr_d  = bus.ir_req_addr;
                    write_d = 1'b0;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            S_REQ: begin
                if (bus.m_req_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.m_resp_valid && m_resp_rdy) begin
                    state_d = S_IDLE;
                    owner_d = O_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = O_NONE;
            end
        endcase
    end

    // State and captured request; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= O_NONE;
            last_q  <= G_INST;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed cycle table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_if bif ();
    bus_arbiter dut (.clk(clk), .rst(rst), .bus(bif));

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bif.ir_req_ready, bif.dr_req_ready, bif.m_req_valid,
                bif.ir_resp_valid, bif.dr_resp_valid, bif.m_resp_ready};
    endfunction

    task automatic clear_inputs();
        bif.ir_req_valid = 0; bif.ir_req_addr = 0; bif.ir_resp_ready = 0;
        bif.dr_req_valid = 0; bif.dr_req_addr = 0; bif.dr_req_write = 0;
        bif.dr_req_wdata = 0; bif.dr_req_wstrb = 0; bif.dr_resp_ready = 0;
        bif.m_req_ready = 0; bif.m_resp_valid = 0; bif.m_resp_data = 0;
    endtask

    typedef struct {
        bit irv; bit [31:0] ira; bit drv; bit [31:0] dra; bit drw;
        bit mrv; bit [31:0] mrd;
        bit e_irr; bit e_drr; bit e_mv; bit [31:0] e_ma; bit e_mw;
        bit e_irv; bit e_drv; bit e_mrr;
    } vec_t;

    vec_t tbl [20];

    // random-phase state
    bit ir_p, dr_p, m_has;
    logic [31:0] ir_a, dr_a, dr_wd, m_d;
    logic dr_w;
    logic [3:0] dr_s;
    int m_dly, ph, own, lastw, grant, ntx;
    logic [68:0] exp_req;
    logic e_ir, e_dr, e_mv, e_irv, e_drv, e_mr;

    initial begin
        tbl = '{
            // fetch only
            '{1,'h100,0,0,0, 0,0,     1,0,0,0,0,     0,0,0},
            '{0,0,0,0,0,     0,0,     0,0,1,'h100,0, 0,0,0},
            '{0,0,0,0,0,     1,'h13,  0,0,0,0,0,     1,0,1},
            '{0,0,0,0,0,     0,0,     0,0,0,0,0,     0,0,0},
            // contention: data, inst, data, inst
            '{1,0,1,'h200,0, 0,0,     0,1,0,0,0,     0,0,0},
            '{1,0,1,'h200,0, 0,0,     0,0,1,'h200,0, 0,0,0},
            '{1,0,1,'h200,0, 1,'hAA,  0,0,0,0,0,     0,1,1},
            '{1,0,1,'h200,0, 0,0,     1,0,0,0,0,     0,0,0},
            '{1,0,1,'h200,0, 0,0,     0,0,1,0,0,     0,0,0},
            '{1,0,1,'h200,0, 1,'hBB,  0,0,0,0,0,     1,0,1},
            '{1,0,1,'h200,0, 0,0,     0,1,0,0,0,     0,0,0},
            '{1,0,1,'h200,0, 0,0,     0,0,1,'h200,0, 0,0,0},
            '{1,0,1,'h200,0, 1,'hCC,  0,0,0,0,0,     0,1,1},
            '{1,0,1,'h200,0, 0,0,     1,0,0,0,0,     0,0,0},
            '{1,0,1,'h200,0, 0,0,     0,0,1,0,0,     0,0,0},
            '{0,0,0,0,0,     1,'hDD,  0,0,0,0,0,     1,0,1},
            // store
            '{0,0,1,'h80,1,  0,0,     0,1,0,0,0,     0,0,0},
            '{0,0,0,0,0,     0,0,     0,0,1,'h80,1,  0,0,0},
            '{0,0,0,0,0,     1,0,     0,0,0,0,0,     0,1,1},
            '{0,0,0,0,0,     0,0,     0,0,0,0,0,     0,0,0}
        };

        clear_inputs();
        rst = 1'b1;
        #12;
        chk("reset ctl", ctl(), 6'b0);
        chk("reset mreq", {bif.m_req_addr, bif.m_req_write, bif.m_req_wdata, bif.m_req_wstrb}, '0);
        chk("reset rdata", {bif.ir_resp_data, bif.dr_resp_data}, '0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bif.ir_req_valid = tbl[i].irv; bif.ir_req_addr = tbl[i].ira;
            bif.dr_req_valid = tbl[i].drv; bif.dr_req_addr = tbl[i].dra;
            bif.dr_req_write = tbl[i].drw;
            bif.dr_req_wdata = tbl[i].drw ? 32'hDEADBEEF : 32'h0;
            bif.dr_req_wstrb = tbl[i].drw ? 4'b0011 : 4'b0000;
            bif.m_req_ready = 1; bif.ir_resp_ready = 1; bif.dr_resp_ready = 1;
            bif.m_resp_valid = tbl[i].mrv; bif.m_resp_data = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("row%0d ctl", i), ctl(),
                {tbl[i].e_irr, tbl[i].e_drr, tbl[i].e_mv, tbl[i].e_irv, tbl[i].e_drv, tbl[i].e_mrr});
            if (tbl[i].e_mv)
                chk($sformatf("row%0d mreq", i),
                    {bif.m_req_addr, bif.m_req_write, bif.m_req_wdata, bif.m_req_wstrb},
                    {tbl[i].e_ma, tbl[i].e_mw, (tbl[i].e_mw ? 32'hDEADBEEF : 32'h0),
                     (tbl[i].e_mw ? 4'b0011 : 4'b0000)});
            if (tbl[i].e_irv)
                chk($sformatf("row%0d irdata", i), bif.ir_resp_data, tbl[i].mrd);
            if (tbl[i].e_drv && tbl[i].mrd != 0)
                chk($sformatf("row%0d drdata", i), bif.dr_resp_data, tbl[i].mrd);
        end

        // ---------------- backpressure + request while busy ----------------
        @(posedge clk); #1;
        clear_inputs();
        bif.dr_req_valid = 1; bif.dr_req_addr = 32'h40; bif.dr_req_write = 1;
        bif.dr_req_wdata = 32'h12345678; bif.dr_req_wstrb = 4'hF; bif.dr_resp_ready = 1;
        @(negedge clk);
        chk("bp grant", {bif.dr_req_ready, bif.ir_req_ready}, 2'b10);
        @(posedge clk); #1;
        bif.dr_req_valid = 0; bif.dr_req_write = 0; bif.dr_req_wdata = 0; bif.dr_req_wstrb = 0;
        bif.ir_req_valid = 1; bif.ir_req_addr = 32'h300;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) bif.m_req_ready = 1;
            @(negedge clk);
            chk($sformatf("bp hold%0d", k),
                {bif.m_req_valid, bif.m_req_addr, bif.m_req_write, bif.m_req_wdata, bif.m_req_wstrb, bif.ir_req_ready},
                {1'b1, 32'h40, 1'b1, 32'h12345678, 4'hF, 1'b0});
            @(posedge clk); #1;
        end
        bif.m_req_ready = 0; bif.m_resp_valid = 1; bif.m_resp_data = 32'h5; bif.dr_resp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp resp stall%0d", k),
                {bif.dr_resp_valid, bif.m_resp_ready, bif.ir_req_ready, bif.ir_resp_valid}, 4'b1000);
            @(posedge clk); #1;
        end
        bif.dr_resp_ready = 1;
        @(negedge clk);
        chk("bp resp done", {bif.dr_resp_valid, bif.m_resp_ready, bif.ir_req_ready}, 3'b110);
        @(posedge clk); #1;
        bif.m_resp_valid = 0;
        @(negedge clk);
        chk("busy req granted", {bif.ir_req_ready, bif.dr_req_ready}, 2'b10);
        @(posedge clk); #1;
        bif.ir_req_valid = 0; bif.m_req_ready = 1;
        @(negedge clk);
        chk("busy req issued", {bif.m_req_valid, bif.m_req_addr, bif.m_req_write, bif.m_req_wstrb},
            {1'b1, 32'h300, 1'b0, 4'h0});
        @(posedge clk); #1;
        bif.m_resp_valid = 1; bif.m_resp_data = 32'h77; bif.ir_resp_ready = 1;
        @(negedge clk);
        chk("busy req resp", {bif.ir_resp_valid, bif.ir_resp_data, bif.dr_resp_valid},
            {1'b1, 32'h77, 1'b0});
        @(posedge clk); #1;
        bif.m_resp_valid = 0;

        // ---------------- async reset mid-REQ ----------------
        bif.dr_req_valid = 1; bif.dr_req_addr = 32'h700; bif.m_req_ready = 0;
        @(negedge clk);
        chk("rst pre grant", bif.dr_req_ready, 1'b1);
        @(posedge clk); #1;
        bif.dr_req_valid = 0;
        @(negedge clk);
        chk("rst pre req", bif.m_req_valid, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst async drop", {bif.m_req_valid, bif.m_req_addr}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        bif.ir_req_valid = 1; bif.ir_req_addr = 32'h0;
        bif.dr_req_valid = 1; bif.dr_req_addr = 32'h600;
        @(negedge clk);
        chk("rst tie to data", {bif.ir_req_ready, bif.dr_req_ready, bif.m_req_valid}, 3'b010);

        // ---------------- randomized traffic ----------------
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        ir_p = 0; dr_p = 0; m_has = 0; m_dly = 0; m_d = 0;
        ph = 0; own = 0; lastw = 0; ntx = 0; exp_req = 0;
        ir_a = 0; dr_a = 0; dr_wd = 0; dr_w = 0; dr_s = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            if (!ir_p && $urandom_range(0, 2) == 0) begin
                ir_p = 1; ir_a = $urandom;
            end
            if (!dr_p && $urandom_range(0, 2) == 0) begin
                dr_p = 1; dr_a = $urandom; dr_w = 1'($urandom_range(0, 1));
                dr_wd = $urandom; dr_s = 4'($urandom);
            end
            bif.ir_req_valid = ir_p; bif.ir_req_addr = ir_p ? ir_a : 32'h0;
            bif.dr_req_valid = dr_p; bif.dr_req_addr = dr_p ? dr_a : 32'h0;
            bif.dr_req_write = dr_p & dr_w; bif.dr_req_wdata = dr_wd; bif.dr_req_wstrb = dr_s;
            bif.m_req_ready = ($urandom_range(0, 2) != 0);
            if (m_has && m_dly > 0) m_dly--;
            bif.m_resp_valid = m_has && (m_dly == 0);
            bif.m_resp_data = m_d;
            bif.ir_resp_ready = ($urandom_range(0, 3) != 0);
            bif.dr_resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_ir = 0; e_dr = 0; e_mv = 0; e_irv = 0; e_drv = 0; e_mr = 0; grant = -1;
            if (ph == 0) begin
                if (ir_p || dr_p) grant = (ir_p && dr_p) ? 1 - lastw : (ir_p ? 0 : 1);
                e_ir = (grant == 0); e_dr = (grant == 1);
            end else if (ph == 1) begin
                e_mv = 1;
            end else begin
                e_irv = (own == 0) && bif.m_resp_valid;
                e_drv = (own == 1) && bif.m_resp_valid;
                e_mr  = (own == 0) ? bif.ir_resp_ready : bif.dr_resp_ready;
            end
            chk($sformatf("rnd%0d ctl", c), ctl(), {e_ir, e_dr, e_mv, e_irv, e_drv, e_mr});
            if (ph == 1) begin
                chk($sformatf("rnd%0d mreq", c),
                    {bif.m_req_addr, bif.m_req_write, bif.m_req_wdata, bif.m_req_wstrb}, exp_req);
                if (bif.m_req_ready) begin
                    ph = 2; m_has = 1; m_dly = $urandom_range(0, 3); m_d = $urandom;
                end
            end else if (ph == 2) begin
                if (e_irv) chk($sformatf("rnd%0d irdata", c), bif.ir_resp_data, m_d);
                if (e_drv && !exp_req[36]) chk($sformatf("rnd%0d drdata", c), bif.dr_resp_data, m_d);
                if (bif.m_resp_valid && e_mr) begin
                    ph = 0; m_has = 0; ntx++;
                end
            end else if (grant >= 0) begin
                lastw = grant; own = grant; ph = 1;
                if (grant == 0) begin
                    exp_req = {ir_a, 1'b0, 32'h0, 4'h0}; ir_p = 0;
                end else begin
                    exp_req = {dr_a, dr_w, dr_wd, dr_s}; dr_p = 0;
                end
            end
        end
        chk("rnd throughput", (ntx > 100), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
